// File: rtl/char_contact_dmg_pkg.sv
// Shared game types: game_active encodings, contact FSM states, coordinate type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package char_contact_dmg_pkg;

    // game_active encodings driven by the game state machine
    localparam logic [1:0] GAME_IDLE = 2'd0;
    localparam logic [1:0] GAME_PLAY = 2'd1;
    localparam logic [1:0] GAME_OVER = 2'd2;
    localparam logic [1:0] GAME_WIN  = 2'd3;

    // screen-space coordinate / extent
    typedef logic [11:0] coord_t;

    // contact damage FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIT    = 2'd1,
        ST_INVULN = 2'd2
    } contact_state_t;

endpackage

// File: rtl/char_contact_dmg_if.sv
// Bundle between character/boss/HP logic and the contact-damage block.
// Latency: n/a (wiring only).
// Backpressure: none; outputs are level/pulse signals sampled by consumers.
interface char_contact_dmg_if;
    import char_contact_dmg_pkg::*;

    logic       frame_tick;
    logic [1:0] game_active;
    coord_t     char_x;
    coord_t     char_y;
    coord_t     char_lng;
    coord_t     char_hgt;
    coord_t     boss_x;
    coord_t     boss_y;
    coord_t     boss_lng;
    coord_t     boss_hgt;
    logic [3:0] char_hp;
    logic       contact;
    logic       hit_pulse;
    logic [3:0] dmg_amt;
    logic       invulnerable;
    logic       blink;
    logic       knock_dir;

    // producer of boxes/ticks, consumer of damage events
    modport master (
        output frame_tick, game_active, char_x, char_y, char_lng, char_hgt,
               boss_x, boss_y, boss_lng, boss_hgt, char_hp,
        input  contact, hit_pulse, dmg_amt, invulnerable, blink, knock_dir
    );

    // the contact-damage block itself
    modport slave (
        input  frame_tick, game_active, char_x, char_y, char_lng, char_hgt,
               boss_x, boss_y, boss_lng, boss_hgt, char_hp,
        output contact, hit_pulse, dmg_amt, invulnerable, blink, knock_dir
    );

endinterface

// File: rtl/char_contact_dmg_aabb.sv
// Strict axis-aligned box overlap test; touching edges and empty boxes never overlap.
// Latency: combinational.
// Backpressure: none.
module aabb_overlap
    import char_contact_dmg_pkg::*;
(
    input  coord_t a_x,
    input  coord_t a_y,
    input  coord_t a_w,
    input  coord_t a_h,
    input  coord_t b_x,
    input  coord_t b_y,
    input  coord_t b_w,
    input  coord_t b_h,
    output logic   overlap
);

    logic [12:0] a_r, a_b, b_r, b_b;
    logic        nonempty, x_hit, y_hit;

    // far edges in 13 bits so boxes near 4095 cannot wrap
    always_comb begin
        a_r      = {1'b0, a_x} + {1'b0, a_w};
        a_b      = {1'b0, a_y} + {1'b0, a_h};
        b_r      = {1'b0, b_x} + {1'b0, b_w};
        b_b      = {1'b0, b_y} + {1'b0, b_h};
        // strict compare alone would let a zero-width box inside the other count
        nonempty = (a_w != '0) && (a_h != '0) && (b_w != '0) && (b_h != '0);
        x_hit    = ({1'b0, a_x} < b_r) && ({1'b0, b_x} < a_r);
        y_hit    = ({1'b0, a_y} < b_b) && ({1'b0, b_y} < a_b);
        overlap  = nonempty && x_hit && y_hit;
    end

endmodule

// File: rtl/char_contact_dmg.sv
// Character/boss contact damage: one hit per contact, frame-counted invulnerability, blink, knockback.
// Latency: contact 1 clk after boxes; hit_pulse 1 clk after the qualifying frame_tick.
// Backpressure: none; hit_pulse is a single-cycle event the HP logic must take when offered.
module char_contact_dmg
    import char_contact_dmg_pkg::*;
#(
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned CONTACT_DMG   = 1,
    parameter int unsigned BLINK_BIT     = 2
)(
    input  logic            clk,
    input  logic            rst,
    char_contact_dmg_if.slave bus
);

    localparam logic [7:0] CNT_INIT = 8'(INVULN_FRAMES);
    localparam logic [3:0] DMG      = 4'(CONTACT_DMG);

    contact_state_t state_q, state_d;
    logic [7:0]     cnt_q;
    logic           contact_q;
    logic [3:0]     dmg_q;
    logic           knock_q;
    logic           overlap;
    logic           play;
    logic [13:0]    char_c2, boss_c2;
    logic           hit_c, inv_c, blink_c;

    aabb_overlap u_overlap (
        .a_x    (bus.char_x),
        .a_y    (bus.char_y),
        .a_w    (bus.char_lng),
        .a_h    (bus.char_hgt),
        .b_x    (bus.boss_x),
        .b_y    (bus.boss_y),
        .b_w    (bus.boss_lng),
        .b_h    (bus.boss_hgt),
        .overlap(overlap)
    );

    assign play = (bus.game_active == GAME_PLAY);

    // doubled centres (2*x + w) keep half-pixel precision without division
    assign char_c2 = {1'b0, bus.char_x, 1'b0} + {2'b00, bus.char_lng};
    assign boss_c2 = {1'b0, bus.boss_x, 1'b0} + {2'b00, bus.boss_lng};

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // next state; leaving gameplay overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.frame_tick && contact_q && bus.char_hp != 4'd0) state_d = ST_HIT;
            ST_HIT:    state_d = ST_INVULN;
            ST_INVULN: if (bus.frame_tick && cnt_q == 8'd1) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (!play) state_d = ST_IDLE;
    end

    // Moore outputs; a HIT cycle that finds gameplay already gone emits nothing
    always_comb begin
        hit_c   = (state_q == ST_HIT) && play;
        inv_c   = (state_q == ST_INVULN);
        blink_c = inv_c && cnt_q[BLINK_BIT];
    end

    // registered overlap and invulnerability frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contact_q <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            contact_q <= overlap;
            if (!play) begin
                cnt_q <= 8'd0;
            end else begin
                case (state_q)
                    ST_HIT:    cnt_q <= CNT_INIT;
                    ST_INVULN: if (bus.frame_tick) cnt_q <= cnt_q - 8'd1;
                    default:   cnt_q <= 8'd0;
                endcase
            end
        end
    end

    // damage and knockback captured on entry to HIT so they are valid alongside hit_pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmg_q   <= 4'd0;
            knock_q <= 1'b0;
        end else if (state_q == ST_IDLE && state_d == ST_HIT) begin
            dmg_q   <= (bus.char_hp < DMG) ? bus.char_hp : DMG;
            knock_q <= (char_c2 >= boss_c2);
        end
    end

    assign bus.contact      = contact_q;
    assign bus.hit_pulse    = hit_c;
    assign bus.dmg_amt      = dmg_q;
    assign bus.invulnerable = inv_c;
    assign bus.blink        = blink_c;
    assign bus.knock_dir    = knock_q;

endmodule

// File: tb/tb_char_contact_dmg.sv
// Bench for char_contact_dmg: directed scenarios plus randomized boxes against a reference model.
// Two instances: default parameters, and a short-window / higher-damage variant.
module tb_char_contact_dmg;
    import char_contact_dmg_pkg::*;

    localparam int INV0 = 60, DMG0 = 1, BB0 = 2;
    localparam int INV1 = 5,  DMG1 = 3, BB1 = 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    char_contact_dmg_if b0();
    char_contact_dmg_if b1();

    char_contact_dmg #(.INVULN_FRAMES(INV0), .CONTACT_DMG(DMG0), .BLINK_BIT(BB0))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    char_contact_dmg #(.INVULN_FRAMES(INV1), .CONTACT_DMG(DMG1), .BLINK_BIT(BB1))
        u1 (.clk(clk), .rst(rst), .bus(b1));

    // ---------------- reference model ----------------
    function automatic bit ref_span(int a, int aw, int b, int bw);
        int lo, hi;
        lo = (a > b) ? a : b;
        hi = ((a + aw) < (b + bw)) ? (a + aw) : (b + bw);
        return (aw > 0) && (bw > 0) && (lo < hi);
    endfunction

    function automatic bit ref_overlap(int cx, int cy, int cl, int ch, int bx, int by, int bl, int bh);
        return ref_span(cx, cl, bx, bl) && ref_span(cy, ch, by, bh);
    endfunction

    function automatic bit ref_knock(int cx, int cl, int bx, int bl);
        return (2 * cx + cl) >= (2 * bx + bl);
    endfunction

    function automatic int ref_dmg(int dmg, int hp);
        return (hp < dmg) ? hp : dmg;
    endfunction

    // frames left after ticks_done ticks of the window, then its blink bit
    function automatic bit ref_blink(int inv_frames, int ticks_done, int bb);
        return (((inv_frames - ticks_done) >> bb) & 1) != 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        b0.frame_tick = 1'b1;
        b1.frame_tick = 1'b1;
        step();
        b0.frame_tick = 1'b0;
        b1.frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic set_boxes(int cx, int cy, int cl, int ch, int bx, int by, int bl, int bh);
        b0.char_x = 12'(cx); b0.char_y = 12'(cy); b0.char_lng = 12'(cl); b0.char_hgt = 12'(ch);
        b0.boss_x = 12'(bx); b0.boss_y = 12'(by); b0.boss_lng = 12'(bl); b0.boss_hgt = 12'(bh);
        b1.char_x = 12'(cx); b1.char_y = 12'(cy); b1.char_lng = 12'(cl); b1.char_hgt = 12'(ch);
        b1.boss_x = 12'(bx); b1.boss_y = 12'(by); b1.boss_lng = 12'(bl); b1.boss_hgt = 12'(bh);
    endtask

    task automatic set_ctl(logic [1:0] ga, int hp);
        b0.game_active = ga; b0.char_hp = 4'(hp);
        b1.game_active = ga; b1.char_hp = 4'(hp);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        b0.frame_tick = 1'b0;
        b1.frame_tick = 1'b0;
        set_ctl(GAME_PLAY, 5);
        set_boxes(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({b0.contact, b0.hit_pulse, b0.dmg_amt, b0.invulnerable, b0.blink, b0.knock_dir} !== 9'd0) begin
            errors++;
            $display("FAIL reset_u0 got %b want 0", {b0.contact, b0.hit_pulse, b0.dmg_amt, b0.invulnerable, b0.blink, b0.knock_dir});
        end
        checks++;
        if ({b1.contact, b1.hit_pulse, b1.dmg_amt, b1.invulnerable, b1.blink, b1.knock_dir} !== 9'd0) begin
            errors++;
            $display("FAIL reset_u1 got %b want 0", {b1.contact, b1.hit_pulse, b1.dmg_amt, b1.invulnerable, b1.blink, b1.knock_dir});
        end
        @(posedge clk);
        #3 rst = 1'b0;
        step();
    endtask

    task automatic test_basic_hit();
        int n;
        apply_reset();
        set_ctl(GAME_PLAY, 5);
        set_boxes(100, 200, 40, 60, 130, 210, 80, 80);
        #1;
        checks++;
        if (b0.contact !== 1'b0) begin errors++; $display("FAIL basic_contact_early got %b want 0", b0.contact); end
        step();
        checks++;
        if (b0.contact !== ref_overlap(100, 200, 40, 60, 130, 210, 80, 80)) begin
            errors++; $display("FAIL basic_contact got %b want 1", b0.contact);
        end
        do_tick();
        checks++;
        if (b0.hit_pulse !== 1'b1) begin errors++; $display("FAIL basic_hit_pulse got %b want 1", b0.hit_pulse); end
        checks++;
        if (b0.dmg_amt !== 4'(ref_dmg(DMG0, 5))) begin
            errors++; $display("FAIL basic_dmg got %0d want %0d", b0.dmg_amt, ref_dmg(DMG0, 5));
        end
        step();
        checks++;
        if (b0.hit_pulse !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0", b0.hit_pulse); end
        checks++;
        if (b0.knock_dir !== ref_knock(100, 40, 130, 80)) begin
            errors++; $display("FAIL basic_knock got %b want %b", b0.knock_dir, ref_knock(100, 40, 130, 80));
        end
        n = 0;
        while (b0.invulnerable === 1'b1 && n < 100) begin
            checks++;
            if (b0.blink !== ref_blink(INV0, n, BB0)) begin
                errors++; $display("FAIL basic_blink frame %0d got %b want %b", n, b0.blink, ref_blink(INV0, n, BB0));
            end
            do_tick();
            n++;
        end
        checks++;
        if (n != INV0) begin errors++; $display("FAIL basic_window got %0d ticks want %0d", n, INV0); end
    endtask

    task automatic test_touching();
        int pulses = 0;
        apply_reset();
        set_ctl(GAME_PLAY, 5);
        set_boxes(90, 200, 40, 60, 130, 210, 80, 80);
        step();
        checks++;
        if (b0.contact !== ref_overlap(90, 200, 40, 60, 130, 210, 80, 80)) begin
            errors++; $display("FAIL touch_contact got %b want 0", b0.contact);
        end
        repeat (10) begin
            do_tick();
            if (b0.hit_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL touch_pulses got %0d want 0", pulses); end
    endtask

    task automatic test_sustained();
        int pulses = 0;
        int exp_pulses = 0;
        int p;
        bit exp_inv;
        apply_reset();
        set_ctl(GAME_PLAY, 9);
        set_boxes(100, 200, 40, 60, 130, 210, 80, 80);
        step();
        for (int t = 1; t <= 150; t++) begin
            p = (t - 1) % (INV0 + 1);
            do_tick();
            if (p == 0) exp_pulses++;
            if (b0.hit_pulse === 1'b1) pulses++;
            checks++;
            if (b0.hit_pulse !== (p == 0)) begin
                errors++; $display("FAIL sustain_pulse tick %0d got %b want %b", t, b0.hit_pulse, (p == 0));
            end
            step();
            step();
            exp_inv = (p != INV0);
            checks++;
            if (b0.invulnerable !== exp_inv) begin
                errors++; $display("FAIL sustain_inv tick %0d got %b want %b", t, b0.invulnerable, exp_inv);
            end
            checks++;
            if (b0.blink !== (exp_inv && ref_blink(INV0, p, BB0))) begin
                errors++; $display("FAIL sustain_blink tick %0d got %b want %b", t, b0.blink, exp_inv && ref_blink(INV0, p, BB0));
            end
        end
        checks++;
        if (pulses != exp_pulses) begin errors++; $display("FAIL sustain_count got %0d want %0d", pulses, exp_pulses); end
    endtask

    task automatic test_hp_limits();
        int pulses = 0;
        int n;
        apply_reset();
        set_ctl(GAME_PLAY, 0);
        set_boxes(100, 200, 40, 60, 130, 210, 80, 80);
        step();
        repeat (10) begin
            do_tick();
            if (b0.hit_pulse === 1'b1 || b1.hit_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL hp0_pulses got %0d want 0", pulses); end
        set_ctl(GAME_PLAY, 2);
        do_tick();
        checks++;
        if (b1.hit_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse got %b want 1", b1.hit_pulse); end
        checks++;
        if (b1.dmg_amt !== 4'(ref_dmg(DMG1, 2))) begin
            errors++; $display("FAIL sat_dmg got %0d want %0d", b1.dmg_amt, ref_dmg(DMG1, 2));
        end
        checks++;
        if (b0.dmg_amt !== 4'(ref_dmg(DMG0, 2))) begin
            errors++; $display("FAIL dflt_dmg got %0d want %0d", b0.dmg_amt, ref_dmg(DMG0, 2));
        end
        // HP drops to zero mid-window; the window must still run to completion
        set_ctl(GAME_PLAY, 0);
        step();
        n = 0;
        while (b1.invulnerable === 1'b1 && n < 20) begin
            checks++;
            if (b1.blink !== ref_blink(INV1, n, BB1)) begin
                errors++; $display("FAIL short_blink frame %0d got %b want %b", n, b1.blink, ref_blink(INV1, n, BB1));
            end
            do_tick();
            n++;
        end
        checks++;
        if (n != INV1) begin errors++; $display("FAIL short_window got %0d ticks want %0d", n, INV1); end
    endtask

    task automatic test_knock_tie();
        apply_reset();
        set_ctl(GAME_PLAY, 5);
        set_boxes(100, 50, 60, 20, 110, 50, 40, 20);
        step();
        do_tick();
        step();
        checks++;
        if (b1.knock_dir !== ref_knock(100, 60, 110, 40)) begin
            errors++; $display("FAIL knock_tie got %b want %b", b1.knock_dir, ref_knock(100, 60, 110, 40));
        end
    endtask

    task automatic test_game_exit();
        apply_reset();
        set_ctl(GAME_PLAY, 5);
        set_boxes(100, 200, 40, 60, 130, 210, 80, 80);
        step();
        do_tick();
        step();
        repeat (20) do_tick();
        checks++;
        if (b0.invulnerable !== 1'b1) begin errors++; $display("FAIL exit_pre_inv got %b want 1", b0.invulnerable); end
        b0.game_active = GAME_OVER;
        b1.game_active = GAME_OVER;
        step();
        checks++;
        if ({b0.invulnerable, b0.blink, b0.hit_pulse} !== 3'b000) begin
            errors++; $display("FAIL exit_outputs got %b want 000", {b0.invulnerable, b0.blink, b0.hit_pulse});
        end
        // back in play the block must be idle and able to hit at once
        set_ctl(GAME_PLAY, 5);
        do_tick();
        checks++;
        if (b0.hit_pulse !== 1'b1) begin errors++; $display("FAIL exit_rehit got %b want 1", b0.hit_pulse); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_ctl(GAME_PLAY, 5);
        set_boxes(200, 200, 40, 60, 130, 210, 80, 80);
        step();
        do_tick();
        step();
        repeat (5) do_tick();
        checks++;
        if ({b0.invulnerable, b0.blink, b0.knock_dir} !== {1'b1, ref_blink(INV0, 5, BB0), ref_knock(200, 40, 130, 80)}) begin
            errors++; $display("FAIL arst_pre got %b want %b", {b0.invulnerable, b0.blink, b0.knock_dir},
                               {1'b1, ref_blink(INV0, 5, BB0), ref_knock(200, 40, 130, 80)});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({b0.contact, b0.hit_pulse, b0.dmg_amt, b0.invulnerable, b0.blink, b0.knock_dir} !== 9'd0) begin
            errors++;
            $display("FAIL arst_mid got %b want 0", {b0.contact, b0.hit_pulse, b0.dmg_amt, b0.invulnerable, b0.blink, b0.knock_dir});
        end
        #1 rst = 1'b0;
        step();
    endtask

    task automatic test_random();
        int cx, cy, cl, ch, bx, by, bl, bh, hp;
        logic [1:0] ga;
        bit ov, exp_hit;
        for (int it = 0; it < 80; it++) begin
            apply_reset();
            if ($urandom_range(0, 1) == 0) begin
                cx = $urandom_range(0, 200); cy = $urandom_range(0, 200);
                bx = $urandom_range(0, 200); by = $urandom_range(0, 200);
                cl = $urandom_range(0, 80);  ch = $urandom_range(0, 80);
                bl = $urandom_range(0, 80);  bh = $urandom_range(0, 80);
            end else begin
                cx = $urandom_range(3900, 4095); cy = $urandom_range(3900, 4095);
                bx = $urandom_range(3900, 4095); by = $urandom_range(3900, 4095);
                cl = $urandom_range(0, 4095);    ch = $urandom_range(0, 4095);
                bl = $urandom_range(0, 4095);    bh = $urandom_range(0, 4095);
            end
            hp = $urandom_range(0, 15);
            ga = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : GAME_PLAY;
            set_ctl(ga, hp);
            set_boxes(cx, cy, cl, ch, bx, by, bl, bh);
            ov = ref_overlap(cx, cy, cl, ch, bx, by, bl, bh);
            exp_hit = ov && (ga == GAME_PLAY) && (hp != 0);
            step();
            checks++;
            if (b1.contact !== ov) begin
                errors++; $display("FAIL rnd_contact it %0d got %b want %b", it, b1.contact, ov);
            end
            do_tick();
            checks++;
            if (b1.hit_pulse !== exp_hit) begin
                errors++; $display("FAIL rnd_pulse it %0d got %b want %b", it, b1.hit_pulse, exp_hit);
            end
            if (exp_hit) begin
                checks++;
                if (b1.dmg_amt !== 4'(ref_dmg(DMG1, hp))) begin
                    errors++; $display("FAIL rnd_dmg it %0d got %0d want %0d", it, b1.dmg_amt, ref_dmg(DMG1, hp));
                end
                step();
                checks++;
                if (b1.knock_dir !== ref_knock(cx, cl, bx, bl)) begin
                    errors++; $display("FAIL rnd_knock it %0d got %b want %b", it, b1.knock_dir, ref_knock(cx, cl, bx, bl));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_touching();
        test_sustained();
        test_hp_limits();
        test_knock_tie();
        test_game_exit();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
